// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with configurable width/depth, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable first-word-fall-through read.
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 14,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned FWFT       = 1,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ae_q, ae_d;
  logic                  af_q, af_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  dvalid_q, dvalid_d;
  logic                  wr_accept, rd_accept;
  logic [AW-1:0]         rd_idx, wr_idx;

  assign rd_idx = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];

  // Acceptance uses the registered flags; read and write are independent.
  always_comb begin
    wr_accept = write_en && !full_q;
    rd_accept = read_en && !empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    dvalid_d = 1'b0;

    if (wr_accept) wr_ptr_d = wr_ptr_q + CW'(1);
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
      rdata_d  = mem_q[rd_idx];
      dvalid_d = 1'b1;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));

    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (write_en && full_q) ovf_d = 1'b1;
    if (read_en && empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata_q  <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata_q  <= rdata_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Storage is not reset; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem_q[wr_idx] <= data_in;
  end

  assign data_out     = (FWFT != 0) ? (empty_q ? '0 : mem_q[rd_idx]) : rdata_q;
  assign data_valid   = (FWFT != 0) ? !empty_q : dvalid_q;
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: an FWFT and a registered-read FIFO share one stimulus stream.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       reset, write_en, read_en, err_clr;
  logic [7:0] data_in;

  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b;
  logic [4:0] count_a, count_b;
  logic       empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
  logic       empty_b, full_b, ae_b, af_b, ovf_b, unf_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .err_clr(err_clr), .data_out(dout_a), .data_valid(dv_a), .count(count_a),
    .empty(empty_a), .full(full_a), .almost_empty(ae_a), .almost_full(af_a),
    .overflow(ovf_a), .underflow(unf_a));

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .err_clr(err_clr), .data_out(dout_b), .data_valid(dv_b), .count(count_b),
    .empty(empty_b), .full(full_b), .almost_empty(ae_b), .almost_full(af_b),
    .overflow(ovf_b), .underflow(unf_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Status of both instances against the expected occupancy-derived flags.
  task automatic chk_st(input string tag, input int c, input logic e, input logic f,
                        input logic ae, input logic af);
    chk({tag, ".count"},   32'(count_a), 32'(c));
    chk({tag, ".empty"},   32'(empty_a), 32'(e));
    chk({tag, ".full"},    32'(full_a),  32'(f));
    chk({tag, ".aempty"},  32'(ae_a),    32'(ae));
    chk({tag, ".afull"},   32'(af_a),    32'(af));
    chk({tag, ".count_b"}, 32'(count_b), 32'(c));
    chk({tag, ".flags_b"}, 32'({empty_b, full_b, ae_b, af_b}), 32'({e, f, ae, af}));
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic rst, input logic we, input logic [7:0] d,
                     input logic re, input logic ec);
    reset = rst; write_en = we; data_in = d; read_en = re; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; write_en = 1'b0; read_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;

    // Reset wins over concurrent requests.
    cyc(1, 1, 8'hEE, 1, 0);
    cyc(1, 1, 8'hEE, 0, 0);
    chk_st("rst", 0, 1, 0, 1, 0);
    chk("rst.ovf_unf", 32'({ovf_a, unf_a, ovf_b, unf_b}), 32'h0);
    chk("rst.dout_a", 32'(dout_a), 32'h00);
    chk("rst.dv_a", 32'(dv_a), 32'h0);
    chk("rst.dout_b", 32'(dout_b), 32'h00);
    chk("rst.dv_b", 32'(dv_b), 32'h0);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 8'(i), 0, 0);
      chk_st("fill", i, 0, i == 16, i <= 2, i >= 14);
      chk("fill.head_a", 32'(dout_a), 32'h01);
      chk("fill.dv_a", 32'(dv_a), 32'h1);
    end
    cyc(0, 1, 8'h99, 0, 0);
    chk_st("ovf", 16, 0, 1, 0, 1);
    chk("ovf.flag", 32'({ovf_a, ovf_b}), 32'h3);

    // Full: simultaneous read/write -> read only.
    cyc(0, 1, 8'h77, 1, 0);
    chk_st("full_rw", 15, 0, 0, 0, 1);
    chk("full_rw.ovf", 32'(ovf_a), 32'h1);
    chk("full_rw.dout_b", 32'(dout_b), 32'h01);
    chk("full_rw.dv_b", 32'(dv_b), 32'h1);
    chk("full_rw.head_a", 32'(dout_a), 32'h02);
    cyc(0, 0, 8'h00, 0, 1);
    chk("errclr.ovf", 32'({ovf_a, ovf_b}), 32'h0);
    chk("errclr.dv_b", 32'(dv_b), 32'h0);
    chk("errclr.hold_b", 32'(dout_b), 32'h01);

    // Drain the remaining 15 entries, 0x02..0x10 in order.
    for (int i = 2; i <= 16; i++) begin
      cyc(0, 0, 8'h00, 1, 0);
      chk_st("drain", 16 - i, i == 16, 0, (16 - i) <= 2, (16 - i) >= 14);
      chk("drain.dout_b", 32'(dout_b), 32'(i));
      chk("drain.dv_b", 32'(dv_b), 32'h1);
    end
    chk("drain.dout_a", 32'(dout_a), 32'h00);
    chk("drain.dv_a", 32'(dv_a), 32'h0);

    // Underflow, then err_clr racing a new underflow (set wins), then a clean clear.
    cyc(0, 0, 8'h00, 1, 0);
    chk_st("unf", 0, 1, 0, 1, 0);
    chk("unf.flag", 32'({unf_a, unf_b}), 32'h3);
    chk("unf.dv_b", 32'(dv_b), 32'h0);
    cyc(0, 0, 8'h00, 1, 1);
    chk("unf.setwins", 32'(unf_a), 32'h1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("unf.clr", 32'({unf_a, unf_b}), 32'h0);

    // Empty: simultaneous read/write -> write only, underflow set.
    cyc(0, 1, 8'h5A, 1, 0);
    chk_st("empty_rw", 1, 0, 0, 1, 0);
    chk("empty_rw.unf", 32'(unf_a), 32'h1);
    chk("empty_rw.dout_a", 32'(dout_a), 32'h5A);
    chk("empty_rw.dv_b", 32'(dv_b), 32'h0);
    cyc(0, 0, 8'h00, 1, 1);
    chk_st("rd_clr", 0, 1, 0, 1, 0);
    chk("rd_clr.unf", 32'(unf_a), 32'h0);
    chk("rd_clr.dout_b", 32'(dout_b), 32'h5A);

    // FWFT write/read of a single word.
    cyc(0, 1, 8'hA5, 0, 0);
    chk("fwft.dout_a", 32'(dout_a), 32'hA5);
    chk("fwft.dv_a", 32'(dv_a), 32'h1);
    chk("fwft.empty", 32'(empty_a), 32'h0);
    cyc(0, 0, 8'h00, 1, 0);
    chk("fwft.empty2", 32'(empty_a), 32'h1);
    chk("fwft.dout_a0", 32'(dout_a), 32'h00);
    chk("fwft.dout_b", 32'(dout_b), 32'hA5);

    // Registered read latency.
    cyc(0, 1, 8'h11, 0, 0);
    cyc(0, 1, 8'h22, 0, 0);
    chk("reg.head_a", 32'(dout_a), 32'h11);
    chk("reg.dv_b_idle", 32'(dv_b), 32'h0);
    cyc(0, 0, 8'h00, 1, 0);
    chk("reg.r1", 32'({dv_b, dout_b}), 32'h111);
    cyc(0, 0, 8'h00, 1, 0);
    chk("reg.r2", 32'({dv_b, dout_b}), 32'h122);
    cyc(0, 0, 8'h00, 0, 0);
    chk("reg.idle", 32'({dv_b, dout_b}), 32'h022);

    // Streaming at occupancy 3 across the pointer wrap.
    cyc(0, 1, 8'h30, 0, 0);
    cyc(0, 1, 8'h31, 0, 0);
    cyc(0, 1, 8'h32, 0, 0);
    for (int k = 0; k < 40; k++) begin
      cyc(0, 1, 8'(8'h33 + k), 1, 0);
      chk_st("stream", 3, 0, 0, 0, 0);
      chk("stream.dout_b", 32'({dv_b, dout_b}), 32'({1'b1, 8'(8'h30 + k)}));
      chk("stream.head_a", 32'(dout_a), 32'(8'h31 + k));
    end

    // Reach 9 entries, then reset during a simultaneous read/write.
    for (int k = 0; k < 6; k++) cyc(0, 1, 8'(8'hC0 + k), 0, 0);
    chk("pre_rst.count", 32'(count_a), 32'd9);
    cyc(1, 1, 8'hDD, 1, 0);
    chk_st("midrst", 0, 1, 0, 1, 0);
    chk("midrst.ovf_unf", 32'({ovf_a, unf_a}), 32'h0);
    chk("midrst.dv", 32'({dv_a, dv_b}), 32'h0);
    chk("midrst.dout", 32'({dout_a, dout_b}), 32'h0);
    cyc(0, 0, 8'h00, 1, 0);
    chk_st("post_rst", 0, 1, 0, 1, 0);
    chk("post_rst.unf", 32'({unf_a, unf_b}), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
